pcs_tx_scrambler: RTL and testbench

// - 10GBASE-R TX self-synchronous scrambler, polynomial G(x) = 1 + x^39 + x^58.
// - Sits between the 64b/66b encoder and the TX gearbox.
// - Consumes each 66b block as two 32-bit halves plus a 2-bit sync header.
// - Scrambles the payload only; passes the sync header unscrambled, aligned to the first half.

---
 rtl/pcs_tx_scrambler_if.sv | 27 ++
 rtl/pcs_tx_scrambler.sv | 105 ++++++++++
 tb/tb_pcs_tx_scrambler.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pcs_tx_scrambler_if.sv
// Encoder-side and gearbox-side signal bundle for the 10GBASE-R TX scrambler.
// The master modport drives words in and receives results; the slave modport is the scrambler.
interface pcs_tx_scrambler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int HDR_WIDTH  = 2
);
  logic [DATA_WIDTH-1:0] i_encoded_data;
  logic [HDR_WIDTH-1:0]  i_sync_hdr;
  logic                  i_valid;
  logic                  i_hdr_valid;
  logic                  i_pause;
  logic [DATA_WIDTH-1:0] o_scrambled_data;
  logic [HDR_WIDTH-1:0]  o_sync_hdr;
  logic                  o_valid;
  logic                  o_hdr_valid;
  logic                  o_seq_err;

  modport master (
    output i_encoded_data, i_sync_hdr, i_valid, i_hdr_valid, i_pause,
    input  o_scrambled_data, o_sync_hdr, o_valid, o_hdr_valid, o_seq_err
  );

  modport slave (
    input  i_encoded_data, i_sync_hdr, i_valid, i_hdr_valid, i_pause,
    output o_scrambled_data, o_sync_hdr, o_valid, o_hdr_valid, o_seq_err
  );
endinterface

// File: rtl/pcs_tx_scrambler.sv
// 10GBASE-R TX self-synchronous scrambler, G(x) = 1 + x^39 + x^58, with block framing check.
// Optional macro PCS_SCRAMBLER_BYPASS_EN adds i_scr_bypass to forward payload unscrambled.
module pcs_tx_scrambler #(
  parameter int          DATA_WIDTH = 32,
  parameter int          HDR_WIDTH  = 2,
  parameter logic [57:0] SCR_SEED   = 58'h3FF_FFFF_FFFF_FFFF
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
`ifdef PCS_SCRAMBLER_BYPASS_EN
  input  logic                 i_scr_bypass,
`endif
  pcs_tx_scrambler_if.slave    bus
);

  logic [57:0]           scr_state_q, scr_state_d;
  logic                  expect_second_q, expect_second_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [HDR_WIDTH-1:0]  hdr_q, hdr_d;
  logic                  valid_q, valid_d;
  logic                  hdr_valid_q, hdr_valid_d;
  logic                  seq_err_q, seq_err_d;

  logic [57:0]           hist;
  logic [DATA_WIDTH-1:0] scr_word;
  logic [DATA_WIDTH-1:0] out_word;
  logic                  hdr_bad;
  logic                  framing_err;

  // hist[0] is the most recent y bit, so y[n-39] sits at hist[38] and y[n-58] at hist[57].
  always_comb begin
    hist     = scr_state_q;
    scr_word = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      scr_word[i] = bus.i_encoded_data[i] ^ hist[38] ^ hist[57];
      hist        = {hist[56:0], scr_word[i]};
    end
  end

  always_comb begin
`ifdef PCS_SCRAMBLER_BYPASS_EN
    out_word = i_scr_bypass ? bus.i_encoded_data : scr_word;
`else
    out_word = scr_word;
`endif
    hdr_bad     = bus.i_hdr_valid &&
                  ((bus.i_sync_hdr == {HDR_WIDTH{1'b0}}) || (bus.i_sync_hdr == {HDR_WIDTH{1'b1}}));
    framing_err = (bus.i_hdr_valid == expect_second_q);
  end

  always_comb begin
    scr_state_d     = scr_state_q;
    expect_second_d = expect_second_q;
    data_d          = data_q;
    hdr_d           = hdr_q;
    valid_d         = valid_q;
    hdr_valid_d     = hdr_valid_q;
    seq_err_d       = seq_err_q;
    // Pause freezes everything, including a pending error pulse, until the gearbox catches up.
    if (!bus.i_pause) begin
      if (bus.i_valid) begin
        scr_state_d     = hist;
        expect_second_d = bus.i_hdr_valid;
        data_d          = out_word;
        valid_d         = 1'b1;
        hdr_valid_d     = bus.i_hdr_valid;
        seq_err_d       = framing_err || hdr_bad;
        if (bus.i_hdr_valid) begin
          hdr_d = bus.i_sync_hdr;
        end
      end else begin
        valid_d     = 1'b0;
        hdr_valid_d = 1'b0;
        seq_err_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      scr_state_q     <= SCR_SEED;
      expect_second_q <= 1'b0;
      data_q          <= '0;
      hdr_q           <= '0;
      valid_q         <= 1'b0;
      hdr_valid_q     <= 1'b0;
      seq_err_q       <= 1'b0;
    end else begin
      scr_state_q     <= scr_state_d;
      expect_second_q <= expect_second_d;
      data_q          <= data_d;
      hdr_q           <= hdr_d;
      valid_q         <= valid_d;
      hdr_valid_q     <= hdr_valid_d;
      seq_err_q       <= seq_err_d;
    end
  end

  assign bus.o_scrambled_data = data_q;
  assign bus.o_sync_hdr       = hdr_q;
  assign bus.o_valid          = valid_q;
  assign bus.o_hdr_valid      = hdr_valid_q;
  assign bus.o_seq_err        = seq_err_q;

endmodule

// File: tb/tb_pcs_tx_scrambler.sv
// Scoreboard bench for pcs_tx_scrambler: bit-serial reference scrambler, framing model,
// and a golden descrambler for random-block loopback.
module tb_pcs_tx_scrambler;

  logic clk;
  logic reset_n;
  logic scr_bypass;

  pcs_tx_scrambler_if #(.DATA_WIDTH(32), .HDR_WIDTH(2)) bus ();

  pcs_tx_scrambler #(
    .DATA_WIDTH(32),
    .HDR_WIDTH(2),
    .SCR_SEED(58'h3FF_FFFF_FFFF_FFFF)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (reset_n),
`ifdef PCS_SCRAMBLER_BYPASS_EN
    .i_scr_bypass(scr_bypass),
`endif
    .bus         (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [31:0] x;
    logic [1:0]  hdr;
    logic        hdr_valid;
    logic        seq_err;
    logic        descr;
  } exp_t;

  exp_t sb_q[$];
  bit   y_hist[$];
  bit   rx_hist[$];
  int   rx_words;
  int   n_compared;
  int   n_mismatched;

  logic        trk_second;
  logic [1:0]  trk_hdr;
  logic [31:0] exp_data;
  logic [1:0]  exp_hdr;
  logic        exp_valid;
  logic        exp_hdr_valid;
  logic        exp_seq_err;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Reference scrambler works directly on the transmitted bit sequence: y_hist[0] is y[n-58].
  task automatic modelScramble(input logic [31:0] x, output logic [31:0] y);
    bit yb;
    for (int i = 0; i < 32; i++) begin
      yb = x[i] ^ y_hist[y_hist.size() - 39] ^ y_hist[y_hist.size() - 58];
      y[i] = yb;
      y_hist.push_back(yb);
      void'(y_hist.pop_front());
    end
  endtask

  task automatic descramble(input logic [31:0] y, output logic [31:0] x);
    for (int i = 0; i < 32; i++) begin
      x[i] = y[i] ^ rx_hist[rx_hist.size() - 39] ^ rx_hist[rx_hist.size() - 58];
      rx_hist.push_back(y[i]);
      void'(rx_hist.pop_front());
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_data"},  {32'h0, bus.o_scrambled_data}, {32'h0, exp_data});
    checkOutput({tag, "_hdr"},   {62'h0, bus.o_sync_hdr},       {62'h0, exp_hdr});
    checkOutput({tag, "_valid"}, {63'h0, bus.o_valid},          {63'h0, exp_valid});
    checkOutput({tag, "_hdrv"},  {63'h0, bus.o_hdr_valid},      {63'h0, exp_hdr_valid});
    checkOutput({tag, "_err"},   {63'h0, bus.o_seq_err},        {63'h0, exp_seq_err});
  endtask

  task automatic applyReset();
    bus.i_valid     = 1'b0;
    bus.i_pause     = 1'b0;
    bus.i_hdr_valid = 1'b0;
    reset_n         = 1'b0;
    @(posedge clk);
    #1;
    y_hist.delete();
    for (int i = 0; i < 58; i++) y_hist.push_back(1'b1);
    sb_q.delete();
    trk_second    = 1'b0;
    trk_hdr       = 2'b00;
    exp_data      = 32'h0;
    exp_hdr       = 2'b00;
    exp_valid     = 1'b0;
    exp_hdr_valid = 1'b0;
    exp_seq_err   = 1'b0;
    checkAll("reset");
    reset_n = 1'b1;
  endtask

  // Called #1 after a rising edge; returns #1 after the next one with outputs checked.
  task automatic applyStimulus(input logic valid, input logic hdr_valid, input logic [1:0] hdr,
                               input logic [31:0] data, input logic pause, input logic bypass,
                               input logic descr, input string tag);
    logic        accepted;
    logic [31:0] y;
    logic [31:0] rx;
    exp_t        e;
    exp_t        got;
    bus.i_valid        = valid;
    bus.i_hdr_valid    = hdr_valid;
    bus.i_sync_hdr     = hdr;
    bus.i_encoded_data = data;
    bus.i_pause        = pause;
    scr_bypass         = bypass;
    accepted = valid && !pause;
    if (accepted) begin
      modelScramble(data, y);
      e.x    = data;
      e.data = y;
`ifdef PCS_SCRAMBLER_BYPASS_EN
      if (bypass) e.data = data;
`endif
      e.hdr       = hdr_valid ? hdr : trk_hdr;
      e.hdr_valid = hdr_valid;
      e.seq_err   = (hdr_valid == trk_second) || (hdr_valid && (hdr == 2'b00 || hdr == 2'b11));
      e.descr     = descr;
      trk_second  = hdr_valid;
      trk_hdr     = e.hdr;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (accepted) begin
      got           = sb_q.pop_front();
      exp_data      = got.data;
      exp_hdr       = got.hdr;
      exp_valid     = 1'b1;
      exp_hdr_valid = got.hdr_valid;
      exp_seq_err   = got.seq_err;
      if (got.descr) begin
        descramble(bus.o_scrambled_data, rx);
        rx_words++;
        if (rx_words > 2) checkOutput("lb_recover", {32'h0, rx}, {32'h0, got.x});
      end
    end else if (!pause) begin
      exp_valid     = 1'b0;
      exp_hdr_valid = 1'b0;
      exp_seq_err   = 1'b0;
    end
    checkAll(tag);
  endtask

  initial begin
    clk                = 1'b0;
    reset_n            = 1'b0;
    scr_bypass         = 1'b0;
    bus.i_encoded_data = 32'h0;
    bus.i_sync_hdr     = 2'b00;
    bus.i_valid        = 1'b0;
    bus.i_hdr_valid    = 1'b0;
    bus.i_pause        = 1'b0;
    n_compared         = 0;
    n_mismatched       = 0;
    rx_words           = 0;
    @(posedge clk);
    #1;

    $display("[TB] basic block");
    applyReset();
    applyStimulus(1, 1, 2'b01, 32'h0, 0, 0, 0, "basic_w1");
    checkOutput("basic_w1_const", {32'h0, bus.o_scrambled_data}, 64'h0);
    checkOutput("basic_w1_hdr",   {62'h0, bus.o_sync_hdr}, 64'h1);
    applyStimulus(1, 0, 2'b00, 32'h0, 0, 0, 0, "basic_w2");
    checkOutput("basic_w2_const", {32'h0, bus.o_scrambled_data}, 64'h03FF_FF80);
    checkOutput("basic_w2_err",   {63'h0, bus.o_seq_err}, 64'h0);
    applyStimulus(0, 0, 2'b00, 32'h0, 0, 0, 0, "idle");

    $display("[TB] pause between halves");
    applyReset();
    applyStimulus(1, 1, 2'b01, 32'h0, 0, 0, 0, "pause_w1");
    for (int i = 0; i < 3; i++)
      applyStimulus(1, i[0], 2'b10, 32'hA5A5_0000 + i, 1, 0, 0, "pause_hold");
    applyStimulus(1, 0, 2'b00, 32'h0, 0, 0, 0, "pause_w2");
    checkOutput("pause_w2_const", {32'h0, bus.o_scrambled_data}, 64'h03FF_FF80);

    $display("[TB] framing faults");
    applyReset();
    applyStimulus(1, 1, 2'b10, 32'h1234_5678, 0, 0, 0, "frm_h1");
    applyStimulus(1, 1, 2'b01, 32'h9ABC_DEF0, 0, 0, 0, "frm_h2");
    checkOutput("frm_missing_err", {63'h0, bus.o_seq_err}, 64'h1);
    applyStimulus(1, 0, 2'b00, 32'h0F0F_0F0F, 0, 0, 0, "frm_s2");
    checkOutput("frm_resync_err", {63'h0, bus.o_seq_err}, 64'h0);
    applyStimulus(1, 1, 2'b01, 32'hCAFE_F00D, 0, 0, 0, "frm_ok1");
    applyStimulus(1, 0, 2'b00, 32'hFFFF_FFFF, 0, 0, 0, "frm_ok2");
    applyStimulus(1, 0, 2'b00, 32'h1111_2222, 0, 0, 0, "frm_orphan");
    checkOutput("frm_orphan_err", {63'h0, bus.o_seq_err}, 64'h1);
    applyStimulus(1, 1, 2'b11, 32'h3333_4444, 0, 0, 0, "frm_bad11");
    checkOutput("frm_bad11_err", {63'h0, bus.o_seq_err}, 64'h1);
    applyStimulus(1, 0, 2'b00, 32'h5555_6666, 0, 0, 0, "frm_bad11_s2");
    checkOutput("frm_bad11_clear", {63'h0, bus.o_seq_err}, 64'h0);
    applyStimulus(1, 1, 2'b00, 32'h7777_8888, 0, 0, 0, "frm_bad00");
    applyStimulus(1, 0, 2'b00, 32'h9999_AAAA, 0, 0, 0, "frm_bad00_s2");

    $display("[TB] mid-block reset");
    applyReset();
    applyStimulus(1, 1, 2'b10, 32'hDEAD_BEEF, 0, 0, 0, "mid_w1");
    applyReset();
    applyStimulus(1, 0, 2'b00, 32'h0, 0, 0, 0, "mid_orphan");
    applyReset();
    applyStimulus(1, 1, 2'b01, 32'h0, 0, 0, 0, "replay_w1");
    checkOutput("replay_w1_const", {32'h0, bus.o_scrambled_data}, 64'h0);
    applyStimulus(1, 0, 2'b00, 32'h0, 0, 0, 0, "replay_w2");
    checkOutput("replay_w2_const", {32'h0, bus.o_scrambled_data}, 64'h03FF_FF80);

`ifdef PCS_SCRAMBLER_BYPASS_EN
    $display("[TB] bypass");
    applyReset();
    applyStimulus(1, 1, 2'b01, 32'h0, 0, 1, 0, "byp_w1");
    checkOutput("byp_w1_const", {32'h0, bus.o_scrambled_data}, 64'h0);
    applyStimulus(1, 0, 2'b00, 32'h0, 0, 0, 0, "byp_w2");
    checkOutput("byp_w2_const", {32'h0, bus.o_scrambled_data}, 64'h03FF_FF80);
    applyReset();
    applyStimulus(1, 1, 2'b10, 32'hDEAD_BEEF, 0, 1, 0, "byp_nz1");
    checkOutput("byp_nz1_const", {32'h0, bus.o_scrambled_data}, 64'hDEAD_BEEF);
    applyStimulus(1, 0, 2'b00, 32'h0123_4567, 0, 0, 0, "byp_nz2");
`endif

    $display("[TB] random loopback");
    applyReset();
    rx_hist.delete();
    for (int i = 0; i < 58; i++) rx_hist.push_back(1'b0);
    rx_words = 0;
    for (int b = 0; b < 10000; b++) begin
      if ($urandom_range(0, 15) == 0) applyStimulus(0, 0, 2'b00, $urandom, 0, 0, 1, "lb_idle");
      applyStimulus(1, 1, ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10, $urandom, 0, 0, 1, "lb_h1");
      if ($urandom_range(0, 7) == 0) applyStimulus(1, 1, 2'b11, $urandom, 1, 0, 1, "lb_pause");
      applyStimulus(1, 0, 2'b00, $urandom, 0, 0, 1, "lb_h2");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
